// File: rtl/snoop_responder.sv
// -----------------------------------------------------------------------------
// snoop_responder
//
// Cache-side coherence snoop responder for one dcache of the dual-core MSI
// system. A snoop offered by the memory controller (ccwait high, non-zero
// ccsnoopaddr) is captured, looked up in the owning dcache's tag/state arrays,
// and answered:
//   - dirty hit           : two-word block written back over dWEN/daddr/dstore,
//                           then the line is downgraded (M->S, or M->I with inv)
//   - clean hit with inv  : line invalidated (S->I)
//   - miss / clean no inv : nothing to do
// While the responder is active the dcache's own controller is held off via
// snoop_busy.
//
// Ports
//   CLK, nRST      clock (rising edge), asynchronous active-low reset
//   ccwait         controller snoop window / hold for this cache
//   ccinv          invalidate request, qualified with ccsnoopaddr
//   ccsnoopaddr    snoop address, 0 = no snoop
//   dwait          data-side wait, 0 = current writeback word accepted
//   dWEN           writeback request
//   daddr, dstore  writeback word address / data
//   snoop_busy     high in every non-idle state
//   snoop_idx      captured set index presented to the frame arrays
//   set_tag        tags of indexed set, way w at [w*TAGW +: TAGW]
//   set_valid      valid bits of indexed set
//   set_dirty      dirty (M) bits of indexed set
//   set_data       block data, way w word0 at [w*64 +: 32], word1 above it
//   upd_en         one-cycle state-update strobe to the frame arrays
//   upd_way        way to update
//   upd_valid      new valid bit
//   upd_dirty      new dirty bit
// -----------------------------------------------------------------------------
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | waiting for a snoop; captures tag/index/inv when one arrives
// S_LOOKUP | frame arrays answer for the captured index; hit/dirty decided
// S_WB0    | writing back word0 of the hit block, held while dwait=1
// S_WB1    | writing back word1 of the hit block, held while dwait=1
// S_UPDATE | one-cycle downgrade/invalidate strobe to the frame arrays
//
module snoop_responder #(
    parameter int SETS = 8,
    parameter int WAYS = 2,
    localparam int IDX  = $clog2(SETS),
    localparam int TAGW = 32 - IDX - 3,
    localparam int WW   = (WAYS > 1) ? $clog2(WAYS) : 1
) (
    input  logic                   CLK,
    input  logic                   nRST,
    input  logic                   ccwait,
    input  logic                   ccinv,
    input  logic [31:0]            ccsnoopaddr,
    input  logic                   dwait,
    output logic                   dWEN,
    output logic [31:0]            daddr,
    output logic [31:0]            dstore,
    output logic                   snoop_busy,
    output logic [IDX-1:0]         snoop_idx,
    input  logic [WAYS*TAGW-1:0]   set_tag,
    input  logic [WAYS-1:0]        set_valid,
    input  logic [WAYS-1:0]        set_dirty,
    input  logic [WAYS*64-1:0]     set_data,
    output logic                   upd_en,
    output logic [WW-1:0]          upd_way,
    output logic                   upd_valid,
    output logic                   upd_dirty
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_WB0,
        S_WB1,
        S_UPDATE
    } state_t;

    state_t state, state_nxt;

    logic [TAGW-1:0] cap_tag;
    logic [IDX-1:0]  cap_idx;
    logic            cap_inv;

    logic [WW-1:0]   hit_way;
    logic [31:0]     wb_word0;
    logic [31:0]     wb_word1;

    logic            snoop_req;
    logic            lk_hit;
    logic [WW-1:0]   lk_way;
    logic            lk_dirty;
    logic [31:0]     lk_word0;
    logic [31:0]     lk_word1;
    logic [31:0]     blk_addr;

    // Byte and word-in-block bits play no part in a block-granular snoop.
    logic            unused_addr_bits;
    assign unused_addr_bits = ^ccsnoopaddr[2:0];

    assign snoop_req  = ccwait && (ccsnoopaddr != 32'd0);
    assign snoop_busy = (state != S_IDLE);
    assign snoop_idx  = cap_idx;
    assign blk_addr   = {cap_tag, cap_idx, 3'b000};

    // Tag match against the captured tag. Scanning from the top way down lets
    // the lowest-numbered matching way overwrite any higher one.
    always_comb begin
        lk_hit   = 1'b0;
        lk_way   = '0;
        lk_dirty = 1'b0;
        lk_word0 = '0;
        lk_word1 = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (set_valid[w] && (set_tag[w*TAGW +: TAGW] == cap_tag)) begin
                lk_hit   = 1'b1;
                lk_way   = WW'(w);
                lk_dirty = set_dirty[w];
                lk_word0 = set_data[w*64 +: 32];
                lk_word1 = set_data[w*64+32 +: 32];
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            cap_tag <= '0;
            cap_idx <= '0;
            cap_inv <= 1'b0;
        end else if ((state == S_IDLE) && snoop_req) begin
            cap_tag <= ccsnoopaddr[31:IDX+3];
            cap_idx <= ccsnoopaddr[IDX+2:3];
            cap_inv <= ccinv;
        end
    end

    // The hit way and its block are frozen at lookup so the writeback and the
    // update see a stable copy even if the arrays change under them.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            hit_way  <= '0;
            wb_word0 <= '0;
            wb_word1 <= '0;
        end else if (state == S_LOOKUP) begin
            hit_way  <= lk_way;
            wb_word0 <= lk_word0;
            wb_word1 <= lk_word1;
        end
    end

    always_comb begin
        state_nxt = state;
        dWEN      = 1'b0;
        daddr     = '0;
        dstore    = '0;
        upd_en    = 1'b0;
        upd_way   = '0;
        upd_valid = 1'b0;
        upd_dirty = 1'b0;
        case (state)
            S_IDLE: begin
                if (snoop_req) begin
                    state_nxt = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                if (lk_hit && lk_dirty) begin
                    state_nxt = S_WB0;
                end else if (lk_hit && cap_inv) begin
                    state_nxt = S_UPDATE;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            S_WB0: begin
                dWEN   = 1'b1;
                daddr  = blk_addr;
                dstore = wb_word0;
                // Losing the snoop window abandons the transfer outright.
                if (!ccwait) begin
                    state_nxt = S_IDLE;
                end else if (!dwait) begin
                    state_nxt = S_WB1;
                end
            end
            S_WB1: begin
                dWEN   = 1'b1;
                daddr  = blk_addr + 32'd4;
                dstore = wb_word1;
                if (!ccwait) begin
                    state_nxt = S_IDLE;
                end else if (!dwait) begin
                    state_nxt = S_UPDATE;
                end
            end
            S_UPDATE: begin
                upd_en    = 1'b1;
                upd_way   = hit_way;
                upd_valid = !cap_inv;
                upd_dirty = 1'b0;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_snoop_responder.sv
module tb_snoop_responder;

    localparam int SETS = 8;
    localparam int WAYS = 2;
    localparam int IDX  = 3;
    localparam int TAGW = 26;

    typedef struct packed {
        logic        busy;
        logic        wen;
        logic [31:0] addr;
        logic [31:0] data;
        logic        upd_en;
        logic        upd_way;
        logic        upd_valid;
        logic        upd_dirty;
    } obs_t;

    logic                  CLK = 1'b0;
    logic                  nRST;
    logic                  ccwait;
    logic                  ccinv;
    logic [31:0]           ccsnoopaddr;
    logic                  dwait;
    logic                  dWEN;
    logic [31:0]           daddr;
    logic [31:0]           dstore;
    logic                  snoop_busy;
    logic [IDX-1:0]        snoop_idx;
    logic [WAYS*TAGW-1:0]  set_tag;
    logic [WAYS-1:0]       set_valid;
    logic [WAYS-1:0]       set_dirty;
    logic [WAYS*64-1:0]    set_data;
    logic                  upd_en;
    logic [0:0]            upd_way;
    logic                  upd_valid;
    logic                  upd_dirty;

    int errors = 0;
    int checks = 0;

    // Frame arrays (environment plus reference state).
    logic [TAGW-1:0] a_tag   [SETS][WAYS];
    logic            a_val   [SETS][WAYS];
    logic            a_dirty [SETS][WAYS];
    logic [31:0]     a_w0    [SETS][WAYS];
    logic [31:0]     a_w1    [SETS][WAYS];

    obs_t exp_q[$];
    bit   dw_q[$];
    bit   cw_q[$];
    obs_t o;

    snoop_responder #(.SETS(SETS), .WAYS(WAYS)) dut (
        .CLK(CLK), .nRST(nRST), .ccwait(ccwait), .ccinv(ccinv),
        .ccsnoopaddr(ccsnoopaddr), .dwait(dwait), .dWEN(dWEN), .daddr(daddr),
        .dstore(dstore), .snoop_busy(snoop_busy), .snoop_idx(snoop_idx),
        .set_tag(set_tag), .set_valid(set_valid), .set_dirty(set_dirty),
        .set_data(set_data), .upd_en(upd_en), .upd_way(upd_way),
        .upd_valid(upd_valid), .upd_dirty(upd_dirty)
    );

    always #5 CLK = ~CLK;

    assign o = {snoop_busy, dWEN, daddr, dstore, upd_en, upd_way, upd_valid, upd_dirty};

    always_comb begin
        set_tag   = '0;
        set_valid = '0;
        set_dirty = '0;
        set_data  = '0;
        for (int w = 0; w < WAYS; w++) begin
            set_tag[w*TAGW +: TAGW]  = a_tag[snoop_idx][w];
            set_valid[w]             = a_val[snoop_idx][w];
            set_dirty[w]             = a_dirty[snoop_idx][w];
            set_data[w*64 +: 32]     = a_w0[snoop_idx][w];
            set_data[w*64+32 +: 32]  = a_w1[snoop_idx][w];
        end
    end

    task automatic push(input obs_t e, input bit dw, input bit cw);
        exp_q.push_back(e);
        dw_q.push_back(dw);
        cw_q.push_back(cw);
    endtask

    task automatic check_obs(input string name, input obs_t exp);
        checks++;
        assert (o === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", name, o, exp);
        end
    endtask

    task automatic set_line(input int s, input int w, input logic [TAGW-1:0] t,
                            input logic v, input logic d,
                            input logic [31:0] x0, input logic [31:0] x1);
        a_tag[s][w] = t; a_val[s][w] = v; a_dirty[s][w] = d;
        a_w0[s][w] = x0; a_w1[s][w] = x1;
    endtask

    // Reference: hit = lowest valid way with matching tag. Dirty hit writes
    // back word0 then word1 (each lasts its wait count + 1 cycles), then the
    // line becomes S (or I with inv). Clean hit with inv goes straight to I.
    // Dropping ccwait in a writeback cycle ends the snoop with no update.
    task automatic run_snoop(input logic [31:0] addr, input logic inv,
                             input int n0, input int n1, input int abort_at,
                             input string name);
        int       idx;
        logic [TAGW-1:0] tag;
        bit       hit, dirty, aborted, do_upd;
        int       way, wbc;
        obs_t     e;
        logic [31:0] base;
        idx = int'(addr[5:3]);
        tag = addr[31:6];
        hit = 0; way = 0; aborted = 0; do_upd = 0; wbc = 0;
        for (int w = 0; w < WAYS; w++) begin
            if (!hit && a_val[idx][w] && a_tag[idx][w] == tag) begin
                hit = 1; way = w;
            end
        end
        dirty = hit && a_dirty[idx][way];
        base  = {tag, 3'(idx), 3'b000};
        exp_q.delete(); dw_q.delete(); cw_q.delete();
        e = '0; e.busy = 1'b1;
        push(e, 1, 1);
        if (dirty) begin
            for (int wd = 0; wd < 2 && !aborted; wd++) begin
                for (int k = 0; k <= (wd == 0 ? n0 : n1); k++) begin
                    e = '0; e.busy = 1'b1; e.wen = 1'b1;
                    e.addr = base + 32'(4 * wd);
                    e.data = (wd == 0) ? a_w0[idx][way] : a_w1[idx][way];
                    push(e, (k == (wd == 0 ? n0 : n1)) ? 1'b0 : 1'b1, (wbc == abort_at) ? 1'b0 : 1'b1);
                    if (wbc == abort_at) begin
                        aborted = 1;
                        break;
                    end
                    wbc++;
                end
            end
            do_upd = !aborted;
        end else if (hit && inv) begin
            do_upd = 1;
        end
        if (do_upd) begin
            e = '0; e.busy = 1'b1; e.upd_en = 1'b1;
            e.upd_way = 1'(way); e.upd_valid = !inv; e.upd_dirty = 1'b0;
            push(e, 1, 1);
        end
        push('0, 1, 0);

        ccwait = 1'b1; ccsnoopaddr = addr; ccinv = inv; dwait = 1'b1;
        for (int k = 0; k < exp_q.size(); k++) begin
            @(posedge CLK); #1;
            check_obs($sformatf("%s c%0d", name, k + 1), exp_q[k]);
            checks++;
            assert (snoop_idx === 3'(idx)) else begin
                errors++;
                $error("FAIL %s idx c%0d: got %0d expected %0d", name, k + 1, snoop_idx, idx);
            end
            ccsnoopaddr = 32'd0; ccinv = 1'b0;
            dwait = dw_q[k]; ccwait = cw_q[k];
        end
        if (do_upd) begin
            a_dirty[idx][way] = 1'b0;
            a_val[idx][way]   = !inv;
        end
    endtask

    initial begin
        logic [31:0] ra;
        int ri, rt, ab;
        for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++)
                set_line(s, w, '0, 1'b0, 1'b0, 32'd0, 32'd0);

        // Reset with a snoop pending: everything must sit at zero.
        nRST = 1'b0; ccwait = 1'b1; ccsnoopaddr = 32'h40; ccinv = 1'b0; dwait = 1'b1;
        #12;
        check_obs("reset_outputs", '0);
        checks++;
        assert (snoop_idx === 3'd0) else begin
            errors++; $error("FAIL reset_idx: got %0d expected 0", snoop_idx);
        end
        ccwait = 1'b0; ccsnoopaddr = 32'd0;
        nRST = 1'b1;
        @(posedge CLK); #1;
        check_obs("after_reset_idle", '0);

        // Dirty hit in way1, no waits.
        set_line(7, 0, 26'h11, 1'b1, 1'b0, 32'h1111_0000, 32'h1111_0004);
        set_line(7, 1, 26'h48, 1'b1, 1'b1, 32'hBEEF_0001, 32'hBEEF_0002);
        run_snoop(32'h1238, 1'b0, 0, 0, -1, "dirty_hit");

        // Dirty hit with inv, each word held 3 cycles.
        set_line(2, 0, 26'h5, 1'b1, 1'b1, 32'hA5A5_0000, 32'hA5A5_0004);
        run_snoop(32'h154, 1'b1, 2, 2, -1, "dirty_inv_wait");

        // Clean hit with inv.
        set_line(0, 1, 26'h2, 1'b1, 1'b0, 32'h0C0C_0000, 32'h0C0C_0004);
        run_snoop(32'h80, 1'b1, 0, 0, -1, "clean_inv");

        // Miss, and a clean hit without inv.
        run_snoop(32'h2238, 1'b0, 0, 0, -1, "miss");
        run_snoop(32'h1238, 1'b0, 0, 0, -1, "clean_noinv");

        // Abort in the first WB1 cycle.
        set_line(4, 0, 26'h9, 1'b1, 1'b1, 32'h9999_0000, 32'h9999_0004);
        run_snoop(32'h260, 1'b0, 1, 1, 2, "abort_wb1");

        // Both ways match: way0 (clean) must win over dirty way1.
        set_line(5, 0, 26'h3, 1'b1, 1'b0, 32'h3030_0000, 32'h3030_0004);
        set_line(5, 1, 26'h3, 1'b1, 1'b1, 32'h3131_0000, 32'h3131_0004);
        run_snoop(32'hE8, 1'b0, 0, 0, -1, "lowest_way");

        // Arbitrate cycles: ccwait with no address.
        ccwait = 1'b1; ccsnoopaddr = 32'd0;
        for (int k = 0; k < 3; k++) begin
            @(posedge CLK); #1;
            check_obs($sformatf("arbitrate c%0d", k), '0);
        end
        ccwait = 1'b0;

        // Reset during WB0.
        set_line(6, 1, 26'h7, 1'b1, 1'b1, 32'h7777_0000, 32'h7777_0004);
        ccwait = 1'b1; ccsnoopaddr = 32'h1F0; ccinv = 1'b0; dwait = 1'b1;
        @(posedge CLK); #1;
        ccsnoopaddr = 32'd0;
        @(posedge CLK); #1;
        check_obs("mid_reset_wb0", {1'b1, 1'b1, 32'h1F0, 32'h7777_0000, 4'b0});
        #2 nRST = 1'b0;
        #1 check_obs("mid_reset_async", '0);
        #2 nRST = 1'b1; ccwait = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(posedge CLK); #1;
            check_obs($sformatf("post_reset c%0d", k), '0);
        end

        // Randomized snoops over a small tag space so hits and double matches occur.
        for (int it = 0; it < 40; it++) begin
            ri = int'($urandom_range(0, SETS - 1));
            for (int w = 0; w < WAYS; w++)
                set_line(ri, w, 26'($urandom_range(1, 3)), 1'($urandom), 1'($urandom),
                         $urandom, $urandom);
            rt = int'($urandom_range(1, 3));
            ra = {26'(rt), 3'(ri), 3'($urandom)};
            ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : -1;
            run_snoop(ra, 1'($urandom), int'($urandom_range(0, 3)),
                      int'($urandom_range(0, 3)), ab, $sformatf("rand%0d", it));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
